rv_decode_stage: RTL

- Registered, parametrised RISC-V (RV32I base) instruction decode stage with valid/ready handshakes on both sides.
- Splits the instruction into its fields: opcode, rd, funct3, rs1, rs2, funct7.
- Also classifies the format (R/I/S/B/U/J), produces the sign-extended immediate and counts decoded instructions.
- Sits between instruction fetch and register-file read; a 2-entry output buffer absorbs back-pressure.

---
 rtl/rv_decode_pkg.sv | 43 ++++
 rtl/rv_imm_gen.sv | 60 ++++++
 rtl/rv_decode_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared opcodes, format codes and decoded-bundle type for the decode stage.
// Build with RV_DECODE_ILLEGAL_EN defined to enable illegal-instruction flagging.
package rv_decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  // Immediate is kept beside this bundle since its width follows XLEN.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_t       fmt;
    logic       illegal;
  } dec_t;

  function automatic logic legal_f7(input logic [6:0] f7);
    return (f7 == 7'b0000000) || (f7 == 7'b0100000);
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I format classifier and sign-extended immediate builder.
// Immediates are widened to XLEN by replicating inst[31].
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  op;
  logic [31:0] imm32;

  assign op = inst[6:0];

  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    unique case (1'b1)
      (op == OP_REG): begin
        fmt = FMT_R;
      end
      (op == OP_IMM || op == OP_LOAD ||
       op == OP_JALR || op == OP_SYSTEM ||
       op == OP_FENCE): begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      (op == OP_STORE): begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25],
                 inst[11:7]};
      end
      (op == OP_BRANCH): begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7],
                 inst[30:25], inst[11:8], 1'b0};
      end
      (op == OP_LUI || op == OP_AUIPC): begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      (op == OP_JAL): begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31],
                 inst[19:12], inst[20],
                 inst[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: field split, format/immediate, 2-entry output buffer.
// Define RV_DECODE_ILLEGAL_EN to drive out_illegal; otherwise it is tied low.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  fmt_t            fmt_in;
  logic [XLEN-1:0] imm_in;
  logic            ill_in;
  dec_t            dec_in;

  rv_imm_gen #(.XLEN(XLEN)) u_imm (
    .inst (in_inst),
    .fmt  (fmt_in),
    .imm  (imm_in)
  );

`ifdef RV_DECODE_ILLEGAL_EN
  logic is_shift;
  logic is_reg;

  assign is_shift = (in_inst[6:0] == OP_IMM) &&
                    (in_inst[13:12] == 2'b01);
  assign is_reg   = (in_inst[6:0] == OP_REG);
  assign ill_in   = (fmt_in == FMT_NONE) ||
                    ((is_shift || is_reg) &&
                     !legal_f7(in_inst[31:25]));
`else
  assign ill_in = 1'b0;
`endif

  assign dec_in = '{
    opcode:  in_inst[6:0],
    rd:      in_inst[11:7],
    funct3:  in_inst[14:12],
    rs1:     in_inst[19:15],
    rs2:     in_inst[24:20],
    funct7:  in_inst[31:25],
    fmt:     fmt_in,
    illegal: ill_in
  };

  dec_t            head_q;
  dec_t            tail_q;
  logic [XLEN-1:0] head_imm_q;
  logic [XLEN-1:0] tail_imm_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic            rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic            push;
  logic            pop;

  assign push    = in_valid && rdy_q;
  assign pop     = (count_q != 2'd0) && out_ready;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  // Head slot is only rewritten on a new entry, so an empty
  // buffer keeps presenting the last popped bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_imm_q <= '0;
      tail_imm_q <= '0;
      count_q    <= 2'd0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      count_q <= count_d;
      rdy_q   <= (count_d != 2'd2);
      if (pop) cnt_q <= cnt_q + 1'b1;
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_q     <= dec_in;
            head_imm_q <= imm_in;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q     <= dec_in;
            head_imm_q <= imm_in;
          end else if (push) begin
            tail_q     <= dec_in;
            tail_imm_q <= imm_in;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q     <= tail_q;
            head_imm_q <= tail_imm_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_opcode  = head_q.opcode;
  assign out_rd      = head_q.rd;
  assign out_funct3  = head_q.funct3;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_funct7  = head_q.funct7;
  assign out_fmt     = head_q.fmt;
  assign out_imm     = head_imm_q;
  assign out_illegal = head_q.illegal;
  assign dec_count   = cnt_q;

endmodule
